// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/sub/accumulate with valid/ready handshake.
// Define MOD_ADDSUB_OPCHECK_EN to flag out-of-range operands on err.
module mod_addsub_pipe #(
  parameter int W = 4,
  parameter int M = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         err,
  output logic [W-1:0] acc
);

  generate
    if (M < 2 || longint'(M) > (64'd1 << W)) begin : g_bad_modulus
      $error("mod_addsub_pipe: M must satisfy 2 <= M <= 2**W");
    end
  endgenerate

  localparam logic [W:0] MOD = (W+1)'(M);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic         r_s1_valid;
  logic [W:0]   r_s1_raw;
  logic         r_s1_err;
  logic         r_out_valid;
  logic [W-1:0] r_z;
  logic         r_err;
  logic [W-1:0] r_acc;

  logic         w_adv1;
  logic         w_adv2;
  logic         w_accept;
  logic         w_op_bad;
  logic [W:0]   w_raw;
  logic [W:0]   w_acc_sum;

  // Single conditional subtract; enough because operands are below M.
  function automatic logic [W-1:0] reduce(input logic [W:0] v);
    logic [W:0] t;
    t = (v >= MOD) ? (v - MOD) : v;
    return t[W-1:0];
  endfunction

  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign w_accept = in_valid && w_adv1;
  assign in_ready = w_adv1;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, x};

`ifdef MOD_ADDSUB_OPCHECK_EN
  assign w_op_bad = ({1'b0, x} >= MOD) || (!op[1] && ({1'b0, y} >= MOD));
`else
  assign w_op_bad = 1'b0;
`endif

  always_comb begin
    w_raw = '0;
    case (op)
      OP_ADD:  w_raw = {1'b0, x} + {1'b0, y};
      OP_SUB:  w_raw = {1'b0, x} + MOD - {1'b0, y};
      OP_ACC:  w_raw = w_acc_sum;
      OP_LOAD: w_raw = {1'b0, x};
      default: w_raw = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_raw    <= '0;
      r_s1_err    <= 1'b0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_err       <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= in_valid;
        if (w_accept) begin
          r_s1_raw <= w_op_bad ? '0 : w_raw;
          r_s1_err <= w_op_bad;
        end
      end
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_z   <= reduce(r_s1_raw);
          r_err <= r_s1_err;
        end
      end
      // Accumulator resolves at accept so chained ACC ops see the new value.
      if (w_accept && !w_op_bad) begin
        if (op == OP_ACC) begin
          r_acc <= reduce(w_acc_sum);
        end else if (op == OP_LOAD) begin
          r_acc <= x;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign z         = r_z;
  assign err       = r_err;
  assign acc       = r_acc;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Randomised and directed bench for mod_addsub_pipe, with a queue-based reference model.
// Also exercises a W=8, M=256 instance with literal expectations.
module tb_mod_addsub_pipe;
  localparam int W = 4;
  localparam int M = 11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]   op;
  logic [W-1:0] x, y, z, acc;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, err8;
  logic [1:0]   op8;
  logic [7:0]   x8, y8, z8, acc8;

  always #5 clk = ~clk;

  mod_addsub_pipe #(.W(W), .M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .err(err), .acc(acc)
  );

  mod_addsub_pipe #(.W(8), .M(256)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8),
    .z(z8), .err(err8), .acc(acc8)
  );

  typedef struct {
    int z;
    bit e;
  } exp_t;

  exp_t q[$];
  int   obs_z[$];
  bit   obs_e[$];
  int   acc_m = 0;
  int   stall_cnt = 0;
  bit   seen_rst = 0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: plain modular arithmetic on integers, accumulator updated on accept.
  function automatic exp_t model(input logic [1:0] o, input int a, input int b);
    exp_t r;
    bit bad;
    bad = 0;
`ifdef MOD_ADDSUB_OPCHECK_EN
    bad = (a >= M) || (o < 2 && b >= M);
`endif
    r.e = bad;
    r.z = 0;
    if (!bad) begin
      case (o)
        2'd0: r.z = (a + b) % M;
        2'd1: r.z = ((a - b) % M + M) % M;
        2'd2: begin acc_m = (acc_m + a) % M; r.z = acc_m; end
        default: begin acc_m = a; r.z = a; end
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (seen_rst) begin
      chk("in_ready", in_ready, (q.size() == 2 && !out_ready) ? 0 : 1);
      chk("acc", acc, acc_m);
      chk("spurious_out_valid", (out_valid && q.size() == 0), 0);
      if (out_valid && q.size() > 0) begin
        chk("z", z, q[0].z);
        chk("err", err, q[0].e);
      end
      stall_cnt = (q.size() > 0 && !out_valid) ? stall_cnt + 1 : 0;
      chk("latency_bound", (stall_cnt >= 2), 0);
    end
    if (!rst_n) begin
      q.delete();
      acc_m = 0;
      stall_cnt = 0;
      seen_rst = 1;
    end else if (seen_rst) begin
      if (out_valid && out_ready && q.size() > 0) begin
        obs_z.push_back(int'(z));
        obs_e.push_back(err);
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(op, int'(x), int'(y)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] o, input int a, input int b);
    in_valid = v;
    op = o;
    x = a[W-1:0];
    y = b[W-1:0];
  endtask

  task automatic send(input logic [1:0] o, input int a, input int b);
    bit ok;
    ok = 0;
    drive(1, o, a, b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    chk("send_accepted", ok, 1);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic clear_obs();
    obs_z.delete();
    obs_e.delete();
  endtask

  task automatic run8(input string name, input logic [1:0] o, input int a, input int b, input int exp);
    bit got;
    got = 0;
    in_valid8 = 1; op8 = o; x8 = a[7:0]; y8 = b[7:0];
    tick();
    in_valid8 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid8) begin got = 1; break; end
    end
    chk({name, "_valid"}, got, 1);
    chk(name, z8, exp);
    tick();
  endtask

  initial begin
    rst_n = 0; out_ready = 1;
    drive(0, 0, 0, 0);
    in_valid8 = 0; out_ready8 = 1; op8 = 0; x8 = 0; y8 = 0;
    tick(); tick();
    rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_err", err, 0);
    chk("rst_acc", acc, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Exhaustive ADD/SUB sweep, back-to-back
    clear_obs();
    for (int o = 0; o < 2; o++)
      for (int a = 0; a < M; a++)
        for (int b = 0; b < M; b++)
          send(o[1:0], a, b);
    drive(0, 0, 0, 0);
    drain();
    chk("sweep_count", obs_z.size(), 2 * M * M);
    chk("spot_7p9", obs_z[7 * M + 9], 5);
    chk("spot_3m8", obs_z[M * M + 3 * M + 8], 6);
    chk("spot_0m0", obs_z[M * M], 0);

    // Accumulator chain
    clear_obs();
    send(2'd3, 4, 0); send(2'd2, 9, 0); send(2'd2, 10, 0); send(2'd2, 0, 0);
    drive(0, 0, 0, 0);
    drain();
    chk("acc_chain_n", obs_z.size(), 4);
    chk("acc_chain0", obs_z[0], 4);
    chk("acc_chain1", obs_z[1], 2);
    chk("acc_chain2", obs_z[2], 1);
    chk("acc_chain3", obs_z[3], 1);
    chk("acc_final", acc, 1);

    // Backpressure
    clear_obs();
    out_ready = 0;
    drive(1, 0, 1, 1);
    @(negedge clk); chk("bp_ready1", in_ready, 1);
    tick(); drive(1, 0, 2, 2);
    @(negedge clk); chk("bp_ready2", in_ready, 1);
    tick(); drive(1, 0, 3, 3);
    @(negedge clk);
    chk("bp_ready3", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_hold_a", z, 2);
    tick();
    @(negedge clk);
    chk("bp_hold_b", z, 2);
    chk("bp_ready3b", in_ready, 0);
    tick(); out_ready = 1;
    @(negedge clk); chk("bp_release_ready", in_ready, 1);
    tick(); drive(0, 0, 0, 0);
    drain();
    chk("bp_n", obs_z.size(), 3);
    chk("bp_z0", obs_z[0], 2);
    chk("bp_z1", obs_z[1], 4);
    chk("bp_z2", obs_z[2], 6);

    // Reset with transactions in flight
    send(2'd3, 7, 0);
    drive(0, 0, 0, 0);
    drain();
    out_ready = 0;
    send(2'd0, 1, 2); send(2'd0, 2, 3);
    drive(0, 0, 0, 0);
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    out_ready = 1;
    clear_obs();
    send(2'd0, 5, 6);
    drive(0, 0, 0, 0);
    drain();
    chk("post_rst_n", obs_z.size(), 1);
    chk("post_rst_z", obs_z[0], 0);

    // Out-of-range operand
    clear_obs();
    send(2'd0, 12, 1); send(2'd0, 1, 2);
    drive(0, 0, 0, 0);
    drain();
`ifdef MOD_ADDSUB_OPCHECK_EN
    chk("oor_err", obs_e[0], 1);
    chk("oor_z", obs_z[0], 0);
`else
    chk("oor_err", obs_e[0], 0);
`endif
    chk("oor_next_err", obs_e[1], 0);
    chk("oor_next_z", obs_z[1], 3);
    chk("oor_acc", acc, 0);

    // Randomised traffic with backpressure and occasional reset
    for (int i = 0; i < 800; i++) begin
      int lim;
`ifdef MOD_ADDSUB_OPCHECK_EN
      lim = (1 << W) - 1;
`else
      lim = M - 1;
`endif
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            int'($urandom_range(0, lim)), int'($urandom_range(0, lim)));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1;
    drive(0, 0, 0, 0);
    out_ready = 1;
    drain();

    // Wide instance
    run8("w8_add", 2'd0, 200, 100, 44);
    run8("w8_sub", 2'd1, 5, 6, 255);
    run8("w8_load", 2'd3, 250, 0, 250);
    run8("w8_acc", 2'd2, 10, 0, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
